// File: rtl/cpu_duv_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_duv_core : multi-cycle 8-bit core running a 6502 instruction subset  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module cpu_duv_core #(
  parameter logic [15:0] RST_VEC = 16'hFFFC,
  parameter logic [7:0]  P_RESET = 8'h24
) (
  input  logic        clk,
  input  logic        b_rst,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        sync,
  output logic [15:0] pc_o,
  output logic [7:0]  a_o,
  output logic [7:0]  x_o,
  output logic [7:0]  y_o,
  output logic [7:0]  p_o,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_RV_LO = 3'd0,
    S_RV_HI = 3'd1,
    S_FETCH = 3'd2,
    S_OP1   = 3'd3,
    S_OP2   = 3'd4,
    S_EXEC  = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d, p_q, p_d;
  logic [7:0]  op_q, op_d, lo_q, lo_d, hi_q, hi_d;
  logic        store_cyc, is_branch, br_taken;
  logic [7:0]  m_eff, cmp_reg, diff;
  logic [8:0]  sum;

  // Status layout NV1BDIZC: N is bit 7, Z is bit 1.
  function automatic logic [7:0] set_nz(input logic [7:0] p, input logic [7:0] r);
    set_nz = {r[7], p[6:2], (r == 8'h00), p[0]};
  endfunction

  always_comb begin
    is_branch = 1'b0;
    br_taken  = 1'b0;
    case (op_q)
      8'hF0: begin is_branch = 1'b1; br_taken =  p_q[1]; end
      8'hD0: begin is_branch = 1'b1; br_taken = ~p_q[1]; end
      8'hB0: begin is_branch = 1'b1; br_taken =  p_q[0]; end
      8'h90: begin is_branch = 1'b1; br_taken = ~p_q[0]; end
      8'h30: begin is_branch = 1'b1; br_taken =  p_q[7]; end
      8'h10: begin is_branch = 1'b1; br_taken = ~p_q[7]; end
      default: ;
    endcase
  end

  // SBC reuses the adder with the operand inverted; compares share one subtractor.
  always_comb begin
    m_eff   = (op_q == 8'hE9) ? ~mem_rdata : mem_rdata;
    sum     = {1'b0, a_q} + {1'b0, m_eff} + {8'd0, p_q[0]};
    cmp_reg = (op_q == 8'hE0) ? x_q : ((op_q == 8'hC0) ? y_q : a_q);
    diff    = cmp_reg - mem_rdata;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    a_d       = a_q;
    x_d       = x_q;
    y_d       = y_q;
    p_d       = p_q;
    op_d      = op_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    mem_addr  = pc_q;
    mem_wdata = a_q;
    store_cyc = 1'b0;
    case (state_q)
      S_RV_LO: begin
        mem_addr  = RST_VEC;
        pc_d[7:0] = mem_rdata;
        state_d   = S_RV_HI;
      end
      S_RV_HI: begin
        mem_addr   = RST_VEC + 16'd1;
        pc_d[15:8] = mem_rdata;
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        op_d    = mem_rdata;
        pc_d    = pc_q + 16'd1;
        state_d = (mem_rdata == 8'h00) ? S_HALT : S_OP1;
      end
      S_OP1: begin
        state_d = S_FETCH;
        case (op_q)
          8'hA9: begin a_d = mem_rdata; p_d = set_nz(p_q, mem_rdata); pc_d = pc_q + 16'd1; end
          8'hA2: begin x_d = mem_rdata; p_d = set_nz(p_q, mem_rdata); pc_d = pc_q + 16'd1; end
          8'hA0: begin y_d = mem_rdata; p_d = set_nz(p_q, mem_rdata); pc_d = pc_q + 16'd1; end
          8'h69, 8'hE9: begin
            a_d    = sum[7:0];
            p_d    = set_nz(p_q, sum[7:0]);
            p_d[0] = sum[8];
            p_d[6] = (a_q[7] == m_eff[7]) && (sum[7] != a_q[7]);
            pc_d   = pc_q + 16'd1;
          end
          8'h29: begin a_d = a_q & mem_rdata; p_d = set_nz(p_q, a_q & mem_rdata); pc_d = pc_q + 16'd1; end
          8'h09: begin a_d = a_q | mem_rdata; p_d = set_nz(p_q, a_q | mem_rdata); pc_d = pc_q + 16'd1; end
          8'h49: begin a_d = a_q ^ mem_rdata; p_d = set_nz(p_q, a_q ^ mem_rdata); pc_d = pc_q + 16'd1; end
          8'hC9, 8'hE0, 8'hC0: begin
            p_d    = set_nz(p_q, diff);
            p_d[0] = (cmp_reg >= mem_rdata);
            pc_d   = pc_q + 16'd1;
          end
          8'hAD, 8'h8D, 8'h8E, 8'h8C, 8'h4C: begin
            lo_d    = mem_rdata;
            pc_d    = pc_q + 16'd1;
            state_d = S_OP2;
          end
          8'hF0, 8'hD0, 8'hB0, 8'h90, 8'h30, 8'h10: begin
            lo_d = mem_rdata;
            pc_d = pc_q + 16'd1;
            if (br_taken) state_d = S_EXEC;
          end
          8'hAA: begin x_d = a_q; p_d = set_nz(p_q, a_q); end
          8'hA8: begin y_d = a_q; p_d = set_nz(p_q, a_q); end
          8'h8A: begin a_d = x_q; p_d = set_nz(p_q, x_q); end
          8'h98: begin a_d = y_q; p_d = set_nz(p_q, y_q); end
          8'hE8: begin x_d = x_q + 8'd1; p_d = set_nz(p_q, x_q + 8'd1); end
          8'hC8: begin y_d = y_q + 8'd1; p_d = set_nz(p_q, y_q + 8'd1); end
          8'hCA: begin x_d = x_q - 8'd1; p_d = set_nz(p_q, x_q - 8'd1); end
          8'h88: begin y_d = y_q - 8'd1; p_d = set_nz(p_q, y_q - 8'd1); end
          8'h18: p_d[0] = 1'b0;
          8'h38: p_d[0] = 1'b1;
          default: ;
        endcase
      end
      S_OP2: begin
        hi_d = mem_rdata;
        pc_d = pc_q + 16'd1;
        if (op_q == 8'h4C) begin
          pc_d    = {mem_rdata, lo_q};
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_branch) begin
          pc_d = pc_q + {{8{lo_q[7]}}, lo_q};
        end else begin
          mem_addr = {hi_q, lo_q};
          case (op_q)
            8'hAD: begin a_d = mem_rdata; p_d = set_nz(p_q, mem_rdata); end
            8'h8D: begin store_cyc = 1'b1; mem_wdata = a_q; end
            8'h8E: begin store_cyc = 1'b1; mem_wdata = x_q; end
            8'h8C: begin store_cyc = 1'b1; mem_wdata = y_q; end
            default: ;
          endcase
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RV_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!b_rst) begin
      state_q <= S_RV_LO;
      pc_q    <= 16'h0000;
      a_q     <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      p_q     <= P_RESET;
      op_q    <= 8'h00;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // Gating with reset keeps an interrupted store from reaching memory.
  assign mem_we = store_cyc & b_rst;
  assign sync   = (state_q == S_FETCH);
  assign halted = (state_q == S_HALT);
  assign pc_o   = pc_q;
  assign a_o    = a_q;
  assign x_o    = x_q;
  assign y_o    = y_q;
  assign p_o    = p_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_duv_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_duv_core : scoreboard bench for cpu_duv_core                      |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_cpu_duv_core;

  logic        clk = 1'b0;
  logic        b_rst;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        sync;
  logic [15:0] pc_o;
  logic [7:0]  a_o, x_o, y_o, p_o;
  logic        halted;

  cpu_duv_core dut (
    .clk       (clk),
    .b_rst     (b_rst),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .sync      (sync),
    .pc_o      (pc_o),
    .a_o       (a_o),
    .x_o       (x_o),
    .y_o       (y_o),
    .p_o       (p_o),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;

  typedef struct packed {
    logic [15:0] fa;
    logic [15:0] pc;
    logic [7:0]  a;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  p;
    logic        h;
    logic [7:0]  cyc;
  } snap_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  cyc;
  } wr_t;

  snap_t exp_q[$];
  wr_t   wr_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cnt    = 0;
  snap_t m_act, m_exp;
  wr_t   w_act, w_exp;

  task automatic exp_sync(input logic [15:0] pc, input logic [7:0] a, input logic [7:0] x,
                          input logic [7:0] y, input logic [7:0] p, input logic [7:0] cyc);
    snap_t s;
    s.fa = pc; s.pc = pc; s.a = a; s.x = x; s.y = y; s.p = p; s.h = 1'b0; s.cyc = cyc;
    exp_q.push_back(s);
  endtask

  task automatic exp_write(input logic [15:0] addr, input logic [7:0] data);
    wr_t w;
    w.addr = addr; w.data = data; w.cyc = 8'd4;
    wr_q.push_back(w);
  endtask

  // Monitor: every opcode fetch shows the state left by the previous instruction.
  always @(negedge clk) begin
    if (b_rst !== 1'b1) begin
      cnt = 0;
    end else begin
      if (sync === 1'b1) begin
        m_act = {mem_addr, pc_o, a_o, x_o, y_o, p_o, halted, cnt[7:0]};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sync_extra: got fa/pc/a/x/y/p/h/cyc=%h required no further fetch", m_act);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_act !== m_exp) begin
            errors++;
            $display("FAIL sync@%h: got fa/pc/a/x/y/p/h/cyc=%h required %h", m_exp.fa, m_act, m_exp);
          end
        end
        cnt = 1;
      end else begin
        cnt++;
      end
      if (mem_we !== 1'b0) begin
        w_act = {mem_addr, mem_wdata, cnt[7:0]};
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL write_extra: got addr/data/cyc=%h we=%b required no write", w_act, mem_we);
        end else begin
          w_exp = wr_q.pop_front();
          if (w_act !== w_exp) begin
            errors++;
            $display("FAIL write: got addr/data/cyc=%h required %h", w_act, w_exp);
          end
        end
      end
    end
  end

  task automatic check_halt(input logic [15:0] want_pc, input string name);
    bit seen, bad;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (halted === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_halt: got halted=%b required 1", name, halted);
    end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pc_o !== want_pc || halted !== 1'b1 || sync !== 1'b0 || mem_we !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_frozen: got pc=%h halted=%b sync=%b we=%b required pc=%h halted=1 sync=0 we=0",
               name, pc_o, halted, sync, mem_we, want_pc);
    end
  endtask

  task automatic check_drain(input string name);
    checks++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got pending syncs=%0d writes=%0d required 0 and 0",
               name, exp_q.size(), wr_q.size());
    end
  endtask

  logic [7:0] prog1 [46];
  logic [7:0] prog2 [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    b_rst = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    mem[16'hFFFC] <= 8'h00;
    mem[16'hFFFD] <= 8'h80;
    prog1 = '{8'hA9, 8'h7F, 8'h69, 8'h01, 8'h69, 8'h80, 8'hA9, 8'h5A,
              8'h8D, 8'h00, 8'h02, 8'hA9, 8'h00, 8'hAD, 8'h00, 8'h02,
              8'hA2, 8'hFF, 8'hE8, 8'hF0, 8'h02, 8'h00, 8'h00, 8'hCA,
              8'hA9, 8'h10, 8'h18, 8'hC9, 8'h10, 8'hA9, 8'h0F, 8'hC9,
              8'h10, 8'hA0, 8'h05, 8'h38, 8'hE9, 8'h0A, 8'h8E, 8'h01,
              8'h02, 8'hF0, 8'h10, 8'h4C, 8'h00, 8'h90};
    for (int i = 0; i < 46; i++) mem[16'h8000 + i[15:0]] <= prog1[i];

    exp_sync(16'h8000, 8'h00, 8'h00, 8'h00, 8'h24, 8'd2);
    exp_sync(16'h8002, 8'h7F, 8'h00, 8'h00, 8'h24, 8'd2);
    exp_sync(16'h8004, 8'h80, 8'h00, 8'h00, 8'hE4, 8'd2);
    exp_sync(16'h8006, 8'h00, 8'h00, 8'h00, 8'h67, 8'd2);
    exp_sync(16'h8008, 8'h5A, 8'h00, 8'h00, 8'h65, 8'd2);
    exp_sync(16'h800B, 8'h5A, 8'h00, 8'h00, 8'h65, 8'd4);
    exp_sync(16'h800D, 8'h00, 8'h00, 8'h00, 8'h67, 8'd2);
    exp_sync(16'h8010, 8'h5A, 8'h00, 8'h00, 8'h65, 8'd4);
    exp_sync(16'h8012, 8'h5A, 8'hFF, 8'h00, 8'hE5, 8'd2);
    exp_sync(16'h8013, 8'h5A, 8'h00, 8'h00, 8'h67, 8'd2);
    exp_sync(16'h8017, 8'h5A, 8'h00, 8'h00, 8'h67, 8'd3);
    exp_sync(16'h8018, 8'h5A, 8'hFF, 8'h00, 8'hE5, 8'd2);
    exp_sync(16'h801A, 8'h10, 8'hFF, 8'h00, 8'h65, 8'd2);
    exp_sync(16'h801B, 8'h10, 8'hFF, 8'h00, 8'h64, 8'd2);
    exp_sync(16'h801D, 8'h10, 8'hFF, 8'h00, 8'h67, 8'd2);
    exp_sync(16'h801F, 8'h0F, 8'hFF, 8'h00, 8'h65, 8'd2);
    exp_sync(16'h8021, 8'h0F, 8'hFF, 8'h00, 8'hE4, 8'd2);
    exp_sync(16'h8023, 8'h0F, 8'hFF, 8'h05, 8'h64, 8'd2);
    exp_sync(16'h8024, 8'h0F, 8'hFF, 8'h05, 8'h65, 8'd2);
    exp_sync(16'h8026, 8'h05, 8'hFF, 8'h05, 8'h25, 8'd2);
    exp_sync(16'h8029, 8'h05, 8'hFF, 8'h05, 8'h25, 8'd4);
    exp_sync(16'h802B, 8'h05, 8'hFF, 8'h05, 8'h25, 8'd2);
    exp_sync(16'h9000, 8'h05, 8'hFF, 8'h05, 8'h25, 8'd3);
    exp_write(16'h0200, 8'h5A);
    exp_write(16'h0201, 8'hFF);

    repeat (5) @(posedge clk);
    #1 b_rst = 1'b1;
    check_halt(16'h9001, "brk1");
    check_drain("prog1");

    // Second program: reset lands in the EXEC cycle of STA, then a clean rerun.
    prog2 = '{8'hA9, 8'h33, 8'h8D, 8'h00, 8'h03, 8'h00};
    for (int i = 0; i < 6; i++) mem[16'h8000 + i[15:0]] <= prog2[i];
    exp_sync(16'h8000, 8'h00, 8'h00, 8'h00, 8'h24, 8'd2);
    exp_sync(16'h8002, 8'h33, 8'h00, 8'h00, 8'h24, 8'd2);
    exp_sync(16'h8000, 8'h00, 8'h00, 8'h00, 8'h24, 8'd2);
    exp_sync(16'h8002, 8'h33, 8'h00, 8'h00, 8'h24, 8'd2);
    exp_sync(16'h8005, 8'h33, 8'h00, 8'h00, 8'h24, 8'd4);
    exp_write(16'h0300, 8'h33);

    @(posedge clk);
    #1 b_rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 b_rst = 1'b1;

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (sync === 1'b1 && mem_addr === 16'h8002) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL sta_fetch_wait: got mem_addr=%h sync=%b required fetch at 8002", mem_addr, sync);
    end
    repeat (3) @(posedge clk);
    #1 b_rst = 1'b0;
    repeat (5) @(posedge clk);
    checks++;
    if (mem[16'h0300] !== 8'h00) begin
      errors++;
      $display("FAIL aborted_store: got mem[0300]=%h required 00", mem[16'h0300]);
    end
    #1 b_rst = 1'b1;
    check_halt(16'h8006, "brk2");
    check_drain("prog2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
